// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage controller feeding the IF/ID pipeline register.
// Owns the program counter, issues word requests to instruction memory over a
// req/ready handshake, and presents the fetched word plus PC+4 to IF/ID. When
// no valid instruction is available it raises fetch_flush so IF/ID loads a
// bubble.
//
// Handshake: imem_req/imem_addr are raised by this block and held stable
// until imem_ready is sampled high at a rising clock edge; imem_rdata is valid
// in that same cycle. A request is never abandoned, even when a redirect
// arrives while it is outstanding. In that case the returning word is
// discarded.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   stall             downstream hold; IF/ID keeps its contents while high
//   redirect_valid    taken branch/jump, next fetch comes from redirect_pc
//   redirect_pc       redirect target, low two bits ignored
//   imem_req          fetch request outstanding
//   imem_addr         word-aligned fetch address
//   imem_ready        memory response strobe (imem_rdata valid this cycle)
//   imem_rdata        fetched instruction
//   pc_plus4_out      PC+4 of the presented instruction
//   instr_out         presented instruction (0 when fetch_valid is low)
//   fetch_valid       instr_out/pc_plus4_out are meaningful this cycle
//   fetch_flush       drives the IF/ID Flush input
//
// The FSM state is held in the 'state' signal for hierarchical observation.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] instr_out,
  output logic        fetch_valid,
  output logic        fetch_flush
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,  // request outstanding at pc
    HOLD   = 2'd1,  // word buffered while downstream stalls
    SQUASH = 2'd2   // wrong-path request still in flight, target in pend_pc
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_instr;
  logic [31:0] pend_pc;

  logic [31:0] target_pc;
  logic [31:0] pc_next4;

  logic        req_c;
  logic [31:0] addr_c;
  logic        valid_c;
  logic [31:0] instr_c;
  logic        flush_c;

  assign target_pc = redirect_pc & 32'hFFFF_FFFC;
  // Wraps naturally at 2^32.
  assign pc_next4  = pc + 32'd4;

  // -------------------------------------------------------------------------
  // Output decode. instr_out must follow imem_rdata in the request cycle for
  // zero-wait memory, so the presented word is combinational from state and
  // the memory response.
  // -------------------------------------------------------------------------
  always_comb begin
    req_c   = 1'b0;
    addr_c  = pc;
    valid_c = 1'b0;
    instr_c = 32'h0;
    case (state)
      FETCH: begin
        req_c   = 1'b1;
        // A word returning in a redirect cycle is wrong-path and is dropped.
        valid_c = imem_ready & ~redirect_valid;
        instr_c = (imem_ready & ~redirect_valid) ? imem_rdata : 32'h0;
      end
      HOLD: begin
        valid_c = 1'b1;
        instr_c = buf_instr;
      end
      SQUASH: begin
        req_c = 1'b1;
      end
      default: begin
        req_c = 1'b0;
      end
    endcase
    // A stalled IF/ID is only flushed when a redirect is present.
    flush_c = redirect_valid | (~valid_c & ~stall);
  end

  assign imem_req     = rst ? 1'b0  : req_c;
  assign imem_addr    = rst ? 32'h0 : addr_c;
  assign fetch_valid  = rst ? 1'b0  : valid_c;
  assign instr_out    = rst ? 32'h0 : instr_c;
  assign pc_plus4_out = rst ? 32'h0 : pc_next4;
  assign fetch_flush  = rst ? 1'b0  : flush_c;

  // -------------------------------------------------------------------------
  // State, PC and buffers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      buf_instr <= 32'h0;
      pend_pc   <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            if (redirect_valid) begin
              pc <= target_pc;
            end else if (!stall) begin
              pc <= pc_next4;
            end else begin
              buf_instr <= imem_rdata;
              state     <= HOLD;
            end
          end else if (redirect_valid) begin
            // Address must stay put until the memory answers.
            pend_pc <= target_pc;
            state   <= SQUASH;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc    <= target_pc;
            state <= FETCH;
          end else if (!stall) begin
            pc    <= pc_next4;
            state <= FETCH;
          end
        end
        SQUASH: begin
          if (redirect_valid) begin
            pend_pc <= target_pc;
          end
          if (imem_ready) begin
            // A redirect in the completing cycle is the newest target.
            pc    <= redirect_valid ? target_pc : pend_pc;
            state <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Two instances share the stimulus inputs: dut_a uses the default reset PC,
// dut_w uses 32'hFFFF_FFFC to exercise PC wrap-around. Each has its own reset.
// Expected outputs are pushed to exp_q as each step is driven and popped and
// compared on the falling edge that follows.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_a;
  logic        rst_w;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic        req_a,   req_w;
  logic [31:0] addr_a,  addr_w;
  logic [31:0] p4_a,    p4_w;
  logic [31:0] instr_a, instr_w;
  logic        fv_a,    fv_w;
  logic        fl_a,    fl_w;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        sel;    // 0: dut_a, 1: dut_w
    logic        req;
    logic [31:0] addr;
    logic        fv;
    logic        fl;
    logic [31:0] ins;
    logic [31:0] p4;
  } exp_t;

  exp_t exp_q[$];

  if_fetch_unit dut_a (
    .clk(clk), .rst(rst_a), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(req_a), .imem_addr(addr_a),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc_plus4_out(p4_a), .instr_out(instr_a),
    .fetch_valid(fv_a), .fetch_flush(fl_a)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(req_w), .imem_addr(addr_w),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc_plus4_out(p4_w), .instr_out(instr_w),
    .fetch_valid(fv_w), .fetch_flush(fl_w)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic s, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic [31:0] rd);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ready     = rdy;
    imem_rdata     = rd;
  endtask

  task automatic expect_out(input logic sel, input logic req, input logic [31:0] addr,
                            input logic fv, input logic fl, input logic [31:0] ins,
                            input logic [31:0] p4);
    exp_t e;
    e.sel = sel; e.req = req; e.addr = addr; e.fv = fv;
    e.fl = fl; e.ins = ins; e.p4 = p4;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Scoreboard: sample on the falling edge, then advance to just past the
  // next rising edge so the next step drives away from the clock edge.
  task automatic check_cycle(input string tag);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      if (e.sel == 1'b0) begin
        cmp({tag, "_req"},   {31'b0, req_a}, {31'b0, e.req});
        if (e.req) cmp({tag, "_addr"}, addr_a, e.addr);
        cmp({tag, "_valid"}, {31'b0, fv_a},  {31'b0, e.fv});
        cmp({tag, "_flush"}, {31'b0, fl_a},  {31'b0, e.fl});
        cmp({tag, "_instr"}, instr_a, e.ins);
        cmp({tag, "_pc4"},   p4_a,    e.p4);
      end else begin
        cmp({tag, "_req"},   {31'b0, req_w}, {31'b0, e.req});
        if (e.req) cmp({tag, "_addr"}, addr_w, e.addr);
        cmp({tag, "_valid"}, {31'b0, fv_w},  {31'b0, e.fv});
        cmp({tag, "_flush"}, {31'b0, fl_w},  {31'b0, e.fl});
        cmp({tag, "_instr"}, instr_w, e.ins);
        cmp({tag, "_pc4"},   p4_w,    e.p4);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_w = 1'b1;
    drive(0, 0, 32'h0, 1, 32'h1111_1111);
    @(posedge clk);
    #1;

    // Reset: all outputs zero on both instances.
    expect_out(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    check_cycle("rst_a");
    expect_out(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    check_cycle("rst_w");

    // Ready memory for 4 cycles.
    rst_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      logic [31:0] a;
      w = $urandom_range(1, 32'h7FFF_FFFF);
      a = 32'h3000 + 32'(i * 4);
      drive(0, 0, 32'h0, 1, w);
      expect_out(0, 1, a, 1, 0, w, a + 32'd4);
      check_cycle("seq");
    end

    // Reset pulse, then 2 wait states on the first fetch.
    rst_a = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0);
    expect_out(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    check_cycle("rst2");
    rst_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 32'h0, 0, 32'hDEAD_BEEF);
      expect_out(0, 1, 32'h3000, 0, 1, 32'h0, 32'h3004);
      check_cycle("wait");
    end
    drive(0, 0, 32'h0, 1, 32'h2408_0005);
    expect_out(0, 1, 32'h3000, 1, 0, 32'h2408_0005, 32'h3004);
    check_cycle("wait_done");

    // Stall for 3 cycles while ready; buffered word held in HOLD.
    drive(1, 0, 32'h0, 1, 32'hAAAA_0001);
    expect_out(0, 1, 32'h3004, 1, 0, 32'hAAAA_0001, 32'h3008);
    check_cycle("stall_in");
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 32'h0, 1, 32'hBBBB_0002);
      expect_out(0, 0, 32'h0, 1, 0, 32'hAAAA_0001, 32'h3008);
      check_cycle("hold");
    end
    drive(0, 0, 32'h0, 1, 32'hBBBB_0002);
    expect_out(0, 0, 32'h0, 1, 0, 32'hAAAA_0001, 32'h3008);
    check_cycle("hold_rel");

    // Redirect to 3040 while request to 3008 waits 2 cycles.
    drive(0, 1, 32'h3040, 0, 32'h0);
    expect_out(0, 1, 32'h3008, 0, 1, 32'h0, 32'h300C);
    check_cycle("rd_wait0");
    drive(0, 0, 32'h0, 0, 32'h0);
    expect_out(0, 1, 32'h3008, 0, 1, 32'h0, 32'h300C);
    check_cycle("rd_wait1");
    drive(0, 0, 32'h0, 1, 32'hCCCC_0003);
    expect_out(0, 1, 32'h3008, 0, 1, 32'h0, 32'h300C);
    check_cycle("rd_done");
    drive(0, 0, 32'h0, 1, 32'hCCCC_0004);
    expect_out(0, 1, 32'h3040, 1, 0, 32'hCCCC_0004, 32'h3044);
    check_cycle("rd_target");

    // Redirect in HOLD with stall high; misaligned target is aligned.
    drive(1, 0, 32'h0, 1, 32'hDDDD_0005);
    expect_out(0, 1, 32'h3044, 1, 0, 32'hDDDD_0005, 32'h3048);
    check_cycle("hold2_in");
    drive(1, 1, 32'h3043, 0, 32'h0);
    expect_out(0, 0, 32'h0, 1, 1, 32'hDDDD_0005, 32'h3048);
    check_cycle("hold_rd");
    drive(0, 0, 32'h0, 1, 32'hEEEE_0006);
    expect_out(0, 1, 32'h3040, 1, 0, 32'hEEEE_0006, 32'h3044);
    check_cycle("hold_rd_tgt");

    // Redirect with ready memory: wrong-path slot flushed.
    drive(0, 1, 32'h3100, 1, 32'h1234_5678);
    expect_out(0, 1, 32'h3044, 0, 1, 32'h0, 32'h3048);
    check_cycle("rd_ready");
    drive(0, 0, 32'h0, 1, 32'h1357_9BDF);
    expect_out(0, 1, 32'h3100, 1, 0, 32'h1357_9BDF, 32'h3104);
    check_cycle("rd_ready_tgt");

    // Redirects during SQUASH: newest target wins, including same-cycle one.
    drive(0, 1, 32'h3200, 0, 32'h0);
    expect_out(0, 1, 32'h3104, 0, 1, 32'h0, 32'h3108);
    check_cycle("sq0");
    drive(0, 1, 32'h3300, 0, 32'h0);
    expect_out(0, 1, 32'h3104, 0, 1, 32'h0, 32'h3108);
    check_cycle("sq1");
    drive(0, 1, 32'h3401, 1, 32'h5555_5555);
    expect_out(0, 1, 32'h3104, 0, 1, 32'h0, 32'h3108);
    check_cycle("sq2");
    drive(0, 0, 32'h0, 1, 32'h6666_0007);
    expect_out(0, 1, 32'h3400, 1, 0, 32'h6666_0007, 32'h3404);
    check_cycle("sq_tgt");

    // Wait state while stalled: bubble but no flush.
    drive(1, 0, 32'h0, 0, 32'h0);
    expect_out(0, 1, 32'h3404, 0, 0, 32'h0, 32'h3408);
    check_cycle("stall_wait");
    drive(0, 0, 32'h0, 1, 32'h7777_0008);
    expect_out(0, 1, 32'h3404, 1, 0, 32'h7777_0008, 32'h3408);
    check_cycle("stall_wait_done");

    // Async reset mid-request drops the pending redirect.
    drive(0, 1, 32'h3500, 0, 32'h0);
    expect_out(0, 1, 32'h3408, 0, 1, 32'h0, 32'h340C);
    check_cycle("pre_arst");
    drive(0, 0, 32'h0, 0, 32'h0);
    #2 rst_a = 1'b1;
    expect_out(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    check_cycle("arst");
    rst_a = 1'b0;
    drive(0, 0, 32'h0, 1, 32'h8888_0009);
    expect_out(0, 1, 32'h3000, 1, 0, 32'h8888_0009, 32'h3004);
    check_cycle("arst_resume");

    // Wrap-around instance.
    rst_w = 1'b0;
    drive(0, 0, 32'h0, 1, 32'h9999_000A);
    expect_out(1, 1, 32'hFFFF_FFFC, 1, 0, 32'h9999_000A, 32'h0);
    check_cycle("wrap0");
    drive(0, 0, 32'h0, 1, 32'h9999_000B);
    expect_out(1, 1, 32'h0, 1, 0, 32'h9999_000B, 32'h4);
    check_cycle("wrap1");
    drive(0, 0, 32'h0, 1, 32'h9999_000C);
    expect_out(1, 1, 32'h4, 1, 0, 32'h9999_000C, 32'h8);
    check_cycle("wrap2");
    drive(0, 0, 32'h0, 1, 32'h9999_000D);
    #2 rst_w = 1'b1;
    expect_out(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    check_cycle("wrap_rst");
    rst_w = 1'b0;
    drive(0, 0, 32'h0, 1, 32'h9999_000E);
    expect_out(1, 1, 32'hFFFF_FFFC, 1, 0, 32'h9999_000E, 32'h0);
    check_cycle("wrap_resume");

    // Final report
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL drain: observed %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage controller feeding the IF/ID pipeline register. Owns the program counter and issues word requests to instruction memory over a req/ready handshake. Presents `pc_plus4_out`/`instr_out` plus a flush strobe that turns IF/ID into a bubble (NOP = 32'h0) when no valid instruction is available. Honours the hazard-unit `stall` and redirects from the branch/jump resolution stage.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `stall`  in  1: downstream hold; IF/ID keeps its contents while high.
- `redirect_valid`  in  1: taken branch/jump; next fetch comes from `redirect_pc`.
- `redirect_pc`  in  32: redirect target; bits [1:0] are ignored and forced to 2'b00.
- `imem_req`  out  1: fetch request outstanding.
- `imem_addr`  out  32: fetch address (word aligned).
- `imem_ready`  in  1: memory response; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32: fetched instruction.
- `pc_plus4_out`  out  32: PC+4 of the presented instruction.
- `instr_out`  out  32: presented instruction.
- `fetch_valid`  out  1: `instr_out`/`pc_plus4_out` are meaningful this cycle.
- `fetch_flush`  out  1: drives the IF/ID Flush input.

## Operation
- Registers:
  - `pc` resets to RESET_PC.
  - `state` resets to FETCH.
  - `buf_instr` resets to 0.
  - `pend_pc` resets to 0.
- While `rst` is high, all outputs are 0.
- FETCH:
  - Drives `imem_req`=1 and `imem_addr`=`pc`.
  - `imem_ready`=1 and `redirect_valid`=1: discard data; `pc`<=`redirect_pc`; stay in FETCH.
  - `imem_ready`=1, no redirect, `stall`=0: present `imem_rdata` and `pc`+4 with `fetch_valid`=1; `pc`<=`pc`+4.
  - `imem_ready`=1, no redirect, `stall`=1: present the same values; `buf_instr`<=`imem_rdata`; go to HOLD.
  - `imem_ready`=0 and `redirect_valid`=1: `pend_pc`<=`redirect_pc`; go to SQUASH. `imem_addr` must not change mid-request.
  - `imem_ready`=0, no redirect: `fetch_valid`=0 (bubble).
- HOLD:
  - Drives `imem_req`=0.
  - Presents `buf_instr` and `pc`+4 with `fetch_valid`=1.
  - `redirect_valid`=1: `pc`<=`redirect_pc`; go to FETCH. Redirect wins over stall.
  - Otherwise, `stall`=0: `pc`<=`pc`+4; go to FETCH.
  - Otherwise stay in HOLD.
- SQUASH:
  - Drives `imem_req`=1 and `imem_addr`=`pc` (the old address); `fetch_valid`=0.
  - A new `redirect_valid` overwrites `pend_pc`.
  - `imem_ready`=1: discard data; `pc`<=`pend_pc`, or `redirect_pc` if a redirect arrives in the same cycle; go to FETCH.
- `fetch_flush` = `redirect_valid` | (~`fetch_valid` & ~`stall`).
  - Never flush a stalled IF/ID unless a redirect is present.
- When `fetch_valid`=0: `instr_out`=0 and `pc_plus4_out`=`pc`+4.
- PC arithmetic is mod 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Zero-wait memory (`imem_ready` tied high): one instruction per cycle; `instr_out` equals `imem_rdata` combinationally in the request cycle.
- N wait states: N bubble cycles with `fetch_flush`=1, then the instruction.
- Redirect penalty with ready memory: the wrong-path slot in the redirect cycle is flushed; the target is fetched the next cycle.
- Redirect during an outstanding request: the flush persists until the old request completes, then the target is fetched the next cycle.
- `imem_req`/`imem_addr` stay stable from assertion until `imem_ready` is sampled high; no request is abandoned.
- Async reset mid-request:
  - State returns to FETCH and the pending redirect is dropped.
  - The memory side shares `rst`, so no stale response is accepted.
- First request: `imem_req`=1 with `imem_addr`=RESET_PC in the first cycle after `rst` falls.

## Test plan
- Reset then ready memory for 4 cycles:
  - `imem_addr` = 3000, 3004, 3008, 300C.
  - `pc_plus4_out` = 3004…3010.
  - `fetch_flush`=0 throughout.
- 2 wait states on the first fetch:
  - `fetch_valid`=0 and `fetch_flush`=1 for 2 cycles, then `instr_out`=`imem_rdata` (e.g. 32'h2408_0005).
  - `imem_addr` holds 3000 throughout.
- Stall for 3 cycles while ready:
  - Enter HOLD; `imem_req`=0; `instr_out` holds the buffered word; `fetch_flush`=0.
  - After release, the next address is `pc`+4.
- Redirect to 32'h0000_3040 while a request to 3008 is waiting 2 cycles:
  - `imem_addr` stays 3008 until ready; `fetch_flush`=1 throughout.
  - Next request is 3040.
- Redirect in HOLD with `stall`=1:
  - `fetch_flush`=1 and the next `imem_addr`=target.
  - `redirect_pc`=32'h3043 yields 32'h3040.
- RESET_PC=32'hFFFF_FFFC with ready memory:
  - Second fetch address is 0; first `pc_plus4_out`=0.
  - `rst` pulsed mid-stream returns `imem_addr` to FFFF_FFFC.
